branch_predictor_btb: RTL and testbench

Parametrised branch target buffer with per-entry saturating direction counters for the RV32I pipeline. It is a direct-mapped table indexed by the fetch PC. Fetch reads it combinationally to pick a speculative next PC. Execute updates it when a branch or jump resolves. It reports mispredictions to the hazard unit and keeps saturating performance counters, so a correctly predicted taken branch no longer costs a D/E flush.

---
 rtl/branch_predictor_btb.sv | 109 ++++++++++
 tb/tb_branch_predictor_btb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with saturating direction counters, mispredict detection and perf counters.
// Latency: lookup and mispredict are combinational (0 cycles); table/counter updates land on the next rising edge.
// Backpressure: none; fetch holds PCF while stalled and every UpdateE pulse is absorbed in one cycle.
module branch_predictor_btb #(
    parameter int PC_W    = 10,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [PC_W-1:0]   PCF,
    output logic              PredTakenF,
    output logic [PC_W-1:0]   PredTargetF,
    input  logic              UpdateE,
    input  logic [PC_W-1:0]   PCE,
    input  logic              TakenE,
    input  logic [PC_W-1:0]   TargetE,
    input  logic              PredTakenE,
    input  logic [PC_W-1:0]   PredTargetE,
    output logic              MispredictE,
    output logic [PC_W-1:0]   RedirectPCE,
    output logic [PERF_W-1:0] BranchCount,
    output logic [PERF_W-1:0] MispredictCount
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] CTR_MAX = '1;
    localparam logic [CNT_W-1:0] CTR_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CTR_WNT = CTR_WT - CNT_W'(1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [CNT_W-1:0] ctr;
    } entry_t;

    entry_t table_q [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_hit;
    logic             unused_lsbs;

    // Instructions are word aligned, so the byte-offset bits never select anything.
    assign unused_lsbs = ^{PCF[1:0], PCE[1:0]};

    assign f_idx = PCF[IDX_W+1:2];
    assign f_tag = PCF[PC_W-1:IDX_W+2];
    assign f_hit = table_q[f_idx].valid && (table_q[f_idx].tag == f_tag);

    // Gated by Reset so fetch never sees stale or uninitialised entries while the table is being cleared.
    assign PredTakenF  = f_hit && table_q[f_idx].ctr[CNT_W-1] && !Reset;
    assign PredTargetF = PredTakenF ? table_q[f_idx].target : PCF + PC_W'(4);

    assign MispredictE = UpdateE &&
                         ((TakenE != PredTakenE) || (TakenE && (TargetE != PredTargetE)));
    assign RedirectPCE = !UpdateE ? '0 : (TakenE ? TargetE : PCE + PC_W'(4));

    assign e_idx = PCE[IDX_W+1:2];
    assign e_tag = PCE[PC_W-1:IDX_W+2];
    assign e_hit = table_q[e_idx].valid && (table_q[e_idx].tag == e_tag);

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid  <= 1'b0;
                table_q[i].tag    <= '0;
                table_q[i].target <= '0;
                table_q[i].ctr    <= CTR_WNT;
            end
        end else if (UpdateE) begin
            if (e_hit) begin
                if (TakenE) begin
                    table_q[e_idx].target <= TargetE;
                    if (table_q[e_idx].ctr != CTR_MAX)
                        table_q[e_idx].ctr <= table_q[e_idx].ctr + CNT_W'(1);
                end else if (table_q[e_idx].ctr != '0) begin
                    table_q[e_idx].ctr <= table_q[e_idx].ctr - CNT_W'(1);
                end
            end else if (TakenE) begin
                // A taken miss evicts whatever aliases onto this slot.
                table_q[e_idx].valid  <= 1'b1;
                table_q[e_idx].tag    <= e_tag;
                table_q[e_idx].target <= TargetE;
                table_q[e_idx].ctr    <= CTR_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            BranchCount     <= '0;
            MispredictCount <= '0;
        end else begin
            if (UpdateE && (BranchCount != '1))
                BranchCount <= BranchCount + PERF_W'(1);
            if (MispredictE && (MispredictCount != '1))
                MispredictCount <= MispredictCount + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: per-cycle comparison against a slot/owner model plus literal checkpoints.
module tb_branch_predictor_btb;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic [9:0] PCF = '0;
    logic       UpdateE = 1'b0;
    logic [9:0] PCE = '0;
    logic       TakenE = 1'b0;
    logic [9:0] TargetE = '0;
    logic       PredTakenE = 1'b0;
    logic [9:0] PredTargetE = '0;

    logic        PredTakenF, MispredictE;
    logic [9:0]  PredTargetF, RedirectPCE;
    logic [31:0] BranchCount, MispredictCount;

    logic       pt4, mis4;
    logic [9:0] tg4, red4;
    logic [3:0] bc4, mc4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_predictor_btb dut (
        .clk(clk), .Reset(Reset), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .UpdateE(UpdateE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE),
        .RedirectPCE(RedirectPCE), .BranchCount(BranchCount), .MispredictCount(MispredictCount)
    );

    branch_predictor_btb #(.PERF_W(4)) dut4 (
        .clk(clk), .Reset(Reset), .PCF(PCF), .PredTakenF(pt4), .PredTargetF(tg4),
        .UpdateE(UpdateE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(mis4),
        .RedirectPCE(red4), .BranchCount(bc4), .MispredictCount(mc4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each slot remembers which word address owns it, its target and a 0..3 confidence.
    bit         m_valid [16];
    logic [7:0] m_word  [16];
    logic [9:0] m_tgt   [16];
    int         m_conf  [16];
    longint     m_branches = 0;
    longint     m_mispred  = 0;
    bit         armed = 1'b0;

    function automatic bit exp_mispredict();
        if (!UpdateE) return 1'b0;
        return (TakenE != PredTakenE) || (TakenE && (TargetE != PredTargetE));
    endfunction

    always @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0;
                m_conf[i]  = 1;
            end
            m_branches = 0;
            m_mispred  = 0;
            armed      = 1'b1;
        end else if (armed && UpdateE) begin
            int s;
            s = int'(PCE[9:2]) % 16;
            m_branches++;
            if (exp_mispredict()) m_mispred++;
            if (m_valid[s] && m_word[s] == PCE[9:2]) begin
                if (TakenE) begin
                    m_tgt[s]  = TargetE;
                    m_conf[s] = (m_conf[s] < 3) ? m_conf[s] + 1 : 3;
                end else begin
                    m_conf[s] = (m_conf[s] > 0) ? m_conf[s] - 1 : 0;
                end
            end else if (TakenE) begin
                m_valid[s] = 1'b1;
                m_word[s]  = PCE[9:2];
                m_tgt[s]   = TargetE;
                m_conf[s]  = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            int         s;
            bit         e_taken;
            logic [9:0] e_tgt;
            logic [9:0] e_red;
            s       = int'(PCF[9:2]) % 16;
            e_taken = !Reset && m_valid[s] && (m_word[s] == PCF[9:2]) && (m_conf[s] >= 2);
            e_tgt   = e_taken ? m_tgt[s] : PCF + 10'd4;
            chk("pred_taken", 32'(PredTakenF), 32'(e_taken));
            chk("pred_target", 32'(PredTargetF), 32'(e_tgt));
            chk("mispredict", 32'(MispredictE), 32'(exp_mispredict()));
            if (UpdateE) begin
                e_red = TakenE ? TargetE : PCE + 10'd4;
                chk("redirect", 32'(RedirectPCE), 32'(e_red));
            end
            chk("branch_count", BranchCount, 32'(m_branches));
            chk("mispredict_count", MispredictCount, 32'(m_mispred));
            chk("branch_count_sat4", 32'(bc4), 32'((m_branches > 15) ? 15 : m_branches));
            chk("mispredict_count_sat4", 32'(mc4), 32'((m_mispred > 15) ? 15 : m_mispred));
        end
    end

    task automatic cyc(input logic rst, input logic [9:0] pcf, input logic upd, input logic [9:0] pce,
                       input logic tk, input logic [9:0] tgt, input logic ptk, input logic [9:0] ptgt);
        @(posedge clk);
        #1;
        Reset = rst; PCF = pcf; UpdateE = upd; PCE = pce;
        TakenE = tk; TargetE = tgt; PredTakenE = ptk; PredTargetE = ptgt;
        @(negedge clk);
        #1;
    endtask

    task automatic look(input logic [9:0] pcf);
        cyc(1'b0, pcf, 1'b0, 10'h0, 1'b0, 10'h0, 1'b0, 10'h0);
    endtask

    initial begin
        cyc(1'b1, 10'h000, 1'b0, 10'h0, 1'b0, 10'h0, 1'b0, 10'h0);
        cyc(1'b1, 10'h000, 1'b0, 10'h0, 1'b0, 10'h0, 1'b0, 10'h0);

        // Empty table: every PC predicts fall-through, including the wrap at the top.
        for (int a = 0; a < 256; a++) look(10'(a * 4));
        chk("lit_sweep_wrap_target", 32'(PredTargetF), 32'h000);
        chk("lit_reset_bcount", BranchCount, 32'd0);

        // First taken branch allocates and mispredicts.
        cyc(1'b0, 10'h040, 1'b1, 10'h040, 1'b1, 10'h010, 1'b0, 10'h044);
        chk("lit_alloc_mispredict", 32'(MispredictE), 32'd1);
        chk("lit_alloc_redirect", 32'(RedirectPCE), 32'h010);
        chk("lit_alloc_no_bypass", 32'(PredTakenF), 32'd0);
        look(10'h040);
        chk("lit_alloc_taken", 32'(PredTakenF), 32'd1);
        chk("lit_alloc_target", 32'(PredTargetF), 32'h010);
        chk("lit_alloc_counts", {BranchCount[15:0], MispredictCount[15:0]}, {16'd1, 16'd1});

        // Saturate, then walk back down.
        repeat (3) cyc(1'b0, 10'h040, 1'b1, 10'h040, 1'b1, 10'h010, 1'b1, 10'h010);
        cyc(1'b0, 10'h040, 1'b1, 10'h040, 1'b0, 10'h000, 1'b1, 10'h010);
        look(10'h040);
        chk("lit_sat_one_nt_taken", 32'(PredTakenF), 32'd1);
        cyc(1'b0, 10'h040, 1'b1, 10'h040, 1'b0, 10'h000, 1'b1, 10'h010);
        look(10'h040);
        chk("lit_sat_two_nt_taken", 32'(PredTakenF), 32'd0);
        chk("lit_sat_two_nt_target", 32'(PredTargetF), 32'h044);
        chk("lit_sat_counts", {BranchCount[15:0], MispredictCount[15:0]}, {16'd6, 16'd3});

        // Aliasing: 0x080 shares 0x040's slot.
        cyc(1'b0, 10'h040, 1'b1, 10'h040, 1'b1, 10'h010, 1'b0, 10'h044);
        look(10'h040);
        chk("lit_alias_owner_taken", 32'(PredTakenF), 32'd1);
        look(10'h080);
        chk("lit_alias_miss", 32'(PredTakenF), 32'd0);
        cyc(1'b0, 10'h080, 1'b1, 10'h080, 1'b1, 10'h100, 1'b0, 10'h084);
        look(10'h080);
        chk("lit_alias_new_target", 32'(PredTargetF), 32'h100);
        look(10'h040);
        chk("lit_alias_evicted", 32'(PredTakenF), 32'd0);
        chk("lit_alias_evicted_target", 32'(PredTargetF), 32'h044);

        // Same-cycle lookup sees pre-update target.
        cyc(1'b0, 10'h040, 1'b1, 10'h040, 1'b1, 10'h010, 1'b0, 10'h044);
        look(10'h040);
        chk("lit_realloc_target", 32'(PredTargetF), 32'h010);
        cyc(1'b0, 10'h040, 1'b1, 10'h040, 1'b1, 10'h020, 1'b1, 10'h010);
        chk("lit_no_bypass_target", 32'(PredTargetF), 32'h010);
        chk("lit_target_change_mispredict", 32'(MispredictE), 32'd1);
        look(10'h040);
        chk("lit_updated_target", 32'(PredTargetF), 32'h020);

        // Reset overrides a simultaneous update and clears everything.
        cyc(1'b1, 10'h040, 1'b1, 10'h300, 1'b1, 10'h050, 1'b0, 10'h000);
        chk("lit_in_reset_pred", 32'(PredTakenF), 32'd0);
        look(10'h040);
        chk("lit_post_reset_miss", 32'(PredTakenF), 32'd0);
        chk("lit_post_reset_counts", {BranchCount[15:0], MispredictCount[15:0]}, 32'd0);
        look(10'h300);
        chk("lit_post_reset_no_alloc", 32'(PredTakenF), 32'd0);

        // Perf counter saturation on the 4-bit instance.
        repeat (20) cyc(1'b0, 10'h200, 1'b1, 10'h200, 1'b1, 10'h100, 1'b0, 10'h204);
        look(10'h200);
        chk("lit_sat4_bcount", 32'(bc4), 32'd15);
        chk("lit_sat4_mcount", 32'(mc4), 32'd15);
        chk("lit_wide_bcount", BranchCount, 32'd20);
        look(10'h000);
        chk("lit_sat4_hold", {28'd0, bc4}, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
